regfile_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: wr0 (ALU writeback) and wr1 (memory-load writeback).
- Drives the register file's two read-address ports for one read requester.
- Compensates for the file's one-cycle registered read: the register file returns the pre-write value on a same-cycle read/write to one address, so this block adds write-to-read bypass.
- Sits between the execute/memory stages and the register file; its `rf_*` ports connect one-to-one to the register file ports.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_arbiter_rr_arb2.sv | 34 +++
 rtl/regfile_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and write-request payload for the register-file arbiter slice.
package regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned CNT_W    = 16;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage : regfile_pkg

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, prio flips on contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    output logic [1:0] gnt
);

    logic prio;

    // Grant is forced low while reset is asserted so no write leaks out.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req0 && req1) begin
                gnt = prio ? 2'b10 : 2'b01;
            end else if (req0) begin
                gnt = 2'b01;
            end else if (req1) begin
                gnt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (req0 && req1) begin
            prio <= ~prio;
        end
    end

endmodule : rr_arb2

// File: rtl/regfile_arbiter.sv
// Write-port arbiter, read-address pass-through and write-to-read bypass for a
// register file with a one-cycle registered read.
module regfile_arbiter #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rf_write_enabled,
    output logic [ADDR_W-1:0] rf_addr_dest,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_addr_reg_a,
    output logic [ADDR_W-1:0] rf_addr_reg_b,
    input  logic [DATA_W-1:0] rf_out_reg_a,
    input  logic [DATA_W-1:0] rf_out_reg_b,
    output logic [15:0]       conflict_count
);

    import regfile_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        gnt;
    logic              hit_a;
    logic              hit_b;
    logic              byp_a;
    logic              byp_b;
    logic [DATA_W-1:0] byp_data_a;
    logic [DATA_W-1:0] byp_data_b;
    logic [CNT_W-1:0]  cnt_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (wr0_valid),
        .req1  (wr1_valid),
        .gnt   (gnt)
    );

    // Write port: granted requester's fields, wr0's when idle.
    always_comb begin
        wr0_ready        = gnt[0];
        wr1_ready        = gnt[1];
        rf_write_enabled = gnt[0] | gnt[1];
        rf_addr_dest     = gnt[1] ? wr1_addr : wr0_addr;
        rf_write_data    = gnt[1] ? wr1_data : wr0_data;
        rf_addr_reg_a    = rd_addr_a;
        rf_addr_reg_b    = rd_addr_b;
    end

    // A transferring write to a read address hides the file's stale read.
    always_comb begin
        hit_a = rd_req && rf_write_enabled && (rf_addr_dest == rd_addr_a);
        hit_b = rd_req && rf_write_enabled && (rf_addr_dest == rd_addr_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid   <= 1'b0;
            byp_a      <= 1'b0;
            byp_b      <= 1'b0;
            byp_data_a <= '0;
            byp_data_b <= '0;
        end else begin
            rd_valid <= rd_req;
            byp_a    <= hit_a;
            byp_b    <= hit_b;
            if (hit_a) begin
                byp_data_a <= rf_write_data;
            end
            if (hit_b) begin
                byp_data_b <= rf_write_data;
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_valid) begin
            rd_data_a = byp_a ? byp_data_a : rf_out_reg_a;
            rd_data_b = byp_b ? byp_data_b : rf_out_reg_b;
        end
    end

    // Saturating count of contested cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wr0_valid && wr1_valid && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign conflict_count = cnt_q;

endmodule : regfile_arbiter

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural registered-read register file.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr0_valid, wr1_valid, rd_req;
    logic [2:0]  wr0_addr, wr1_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr0_data, wr1_data;
    logic        wr0_ready, wr1_ready, rd_valid, rf_write_enabled;
    logic [15:0] rd_data_a, rd_data_b, rf_write_data, rf_out_reg_a, rf_out_reg_b;
    logic [2:0]  rf_addr_dest, rf_addr_reg_a, rf_addr_reg_b;
    logic [15:0] conflict_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr0_valid        (wr0_valid),
        .wr0_addr         (wr0_addr),
        .wr0_data         (wr0_data),
        .wr0_ready        (wr0_ready),
        .wr1_valid        (wr1_valid),
        .wr1_addr         (wr1_addr),
        .wr1_data         (wr1_data),
        .wr1_ready        (wr1_ready),
        .rd_req           (rd_req),
        .rd_addr_a        (rd_addr_a),
        .rd_addr_b        (rd_addr_b),
        .rd_valid         (rd_valid),
        .rd_data_a        (rd_data_a),
        .rd_data_b        (rd_data_b),
        .rf_write_enabled (rf_write_enabled),
        .rf_addr_dest     (rf_addr_dest),
        .rf_write_data    (rf_write_data),
        .rf_addr_reg_a    (rf_addr_reg_a),
        .rf_addr_reg_b    (rf_addr_reg_b),
        .rf_out_reg_a     (rf_out_reg_a),
        .rf_out_reg_b     (rf_out_reg_b),
        .conflict_count   (conflict_count)
    );

    // Register file: write at edge, registered read returns the pre-write value.
    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (rf_write_enabled) mem[rf_addr_dest] <= rf_write_data;
        rf_out_reg_a <= mem[rf_addr_reg_a];
        rf_out_reg_b <= mem[rf_addr_reg_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_valid = 1'b0; wr1_valid = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        int alt_err;
        int exp_cnt;
        rst_n = 1'b0;
        rd_req = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        wr0_valid = 1'b1; wr0_addr = 3'd1; wr0_data = 16'hAAAA;
        wr1_valid = 1'b1; wr1_addr = 3'd2; wr1_data = 16'h5555;
        #1;
        check("rst_wr0_ready", 32'(wr0_ready), 32'd0);
        check("rst_wr1_ready", 32'(wr1_ready), 32'd0);
        check("rst_rf_we", 32'(rf_write_enabled), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data_a", 32'(rd_data_a), 32'd0);
        check("rst_cnt", 32'(conflict_count), 32'd0);
        tick(); tick();

        // Contention held from reset: wr0 first, then wr1.
        rst_n = 1'b1;
        #1;
        check("cont0_wr0_ready", 32'(wr0_ready), 32'd1);
        check("cont0_wr1_ready", 32'(wr1_ready), 32'd0);
        check("cont0_dest", 32'(rf_addr_dest), 32'd1);
        check("cont0_data", 32'(rf_write_data), 32'hAAAA);
        tick();
        wr0_valid = 1'b0;
        #1;
        check("cont1_wr1_ready", 32'(wr1_ready), 32'd1);
        check("cont1_wr0_ready", 32'(wr0_ready), 32'd0);
        check("cont1_dest", 32'(rf_addr_dest), 32'd2);
        check("cont1_data", 32'(rf_write_data), 32'h5555);
        tick();
        idle();
        check("cont_cnt", 32'(conflict_count), 32'd1);

        // Read back r1/r2; addresses pass through combinationally.
        rd_req = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd2;
        #1;
        check("rd_addr_a_pass", 32'(rf_addr_reg_a), 32'd1);
        check("rd_addr_b_pass", 32'(rf_addr_reg_b), 32'd2);
        check("idle_we", 32'(rf_write_enabled), 32'd0);
        tick();
        rd_req = 1'b0; rd_addr_a = 3'd6; rd_addr_b = 3'd7;
        #1;
        check("rd12_valid", 32'(rd_valid), 32'd1);
        check("rd12_a", 32'(rd_data_a), 32'hAAAA);
        check("rd12_b", 32'(rd_data_b), 32'h5555);
        check("rd_addr_ungated", 32'(rf_addr_reg_b), 32'd7);
        tick();
        check("rd_drop_valid", 32'(rd_valid), 32'd0);
        check("rd_drop_data", 32'(rd_data_a), 32'd0);

        // Single write r3 = 0x1234, read next cycle.
        wr0_valid = 1'b1; wr0_addr = 3'd3; wr0_data = 16'h1234;
        #1;
        check("single_wr0_ready", 32'(wr0_ready), 32'd1);
        check("single_wr1_ready", 32'(wr1_ready), 32'd0);
        check("single_we", 32'(rf_write_enabled), 32'd1);
        tick();
        idle();
        rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        tick();
        rd_req = 1'b0;
        #1;
        check("single_rd_valid", 32'(rd_valid), 32'd1);
        check("single_rd_a", 32'(rd_data_a), 32'h1234);

        // Bypass: r5 = 0x0001, then write 0xBEEF while reading r5 on both operands.
        tick();
        wr1_valid = 1'b1; wr1_addr = 3'd5; wr1_data = 16'h0001;
        #1;
        check("preset_wr1_ready", 32'(wr1_ready), 32'd1);
        tick();
        idle();
        wr0_valid = 1'b1; wr0_addr = 3'd5; wr0_data = 16'hBEEF;
        rd_req = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        tick();
        idle();
        #1;
        check("byp_valid", 32'(rd_valid), 32'd1);
        check("byp_a", 32'(rd_data_a), 32'hBEEF);
        check("byp_b", 32'(rd_data_b), 32'hBEEF);

        // Independent operands: A bypasses r6, B reads r5 from the file.
        wr0_valid = 1'b1; wr0_addr = 3'd6; wr0_data = 16'h6666;
        rd_req = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd5;
        tick();
        idle();
        #1;
        check("byp_ind_a", 32'(rd_data_a), 32'h6666);
        check("byp_ind_b", 32'(rd_data_b), 32'hBEEF);

        // Non-bypass: a write in the rd_valid cycle is not reflected.
        wr0_valid = 1'b1; wr0_addr = 3'd4; wr0_data = 16'h7777;
        rd_req = 1'b1; rd_addr_a = 3'd4; rd_addr_b = 3'd4;
        tick();
        rd_req = 1'b0; wr0_data = 16'h8888;
        #1;
        check("nobyp_a", 32'(rd_data_a), 32'h7777);
        tick();
        idle();
        rd_req = 1'b1;
        tick();
        idle();
        #1;
        check("nobyp_later_a", 32'(rd_data_a), 32'h8888);

        // Contested write with bypass: prio=1 so wr1 wins, bypass takes wr1 data.
        wr0_valid = 1'b1; wr0_addr = 3'd7; wr0_data = 16'h1111;
        wr1_valid = 1'b1; wr1_addr = 3'd7; wr1_data = 16'h2222;
        rd_req = 1'b1; rd_addr_a = 3'd7; rd_addr_b = 3'd0;
        #1;
        check("prio1_wr1_ready", 32'(wr1_ready), 32'd1);
        check("prio1_wr0_ready", 32'(wr0_ready), 32'd0);
        tick();
        wr1_valid = 1'b0; rd_req = 1'b0;
        #1;
        check("prio1_byp_a", 32'(rd_data_a), 32'h2222);
        check("prio1_then_wr0", 32'(wr0_ready), 32'd1);
        check("cnt_two", 32'(conflict_count), 32'd2);
        tick();
        idle();

        // Saturation: 70000 contested cycles, grants alternate starting at wr0.
        wr0_valid = 1'b1; wr0_addr = 3'd0; wr0_data = 16'h0F0F;
        wr1_valid = 1'b1; wr1_addr = 3'd0; wr1_data = 16'hF0F0;
        alt_err = 0;
        exp_cnt = 2;
        for (int k = 0; k < 70000; k++) begin
            #1;
            if (wr0_ready !== ((k % 2) == 0) || wr1_ready !== ((k % 2) == 1)) alt_err++;
            if (32'(conflict_count) != 32'(exp_cnt)) alt_err++;
            tick();
            if (exp_cnt < 65535) exp_cnt++;
        end
        check("sat_alternate_and_count", 32'(alt_err), 32'd0);
        check("sat_cnt", 32'(conflict_count), 32'hFFFF);
        tick();
        check("sat_hold", 32'(conflict_count), 32'hFFFF);

        // Async reset mid-read: prio left at 1, rd_valid pending.
        rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        #1;
        check("pre_rst_grant", 32'(wr1_ready), 32'd1);
        tick();
        rd_req = 1'b0;
        #1;
        check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_rd_a", 32'(rd_data_a), 32'd0);
        check("midrst_wr0_ready", 32'(wr0_ready), 32'd0);
        check("midrst_wr1_ready", 32'(wr1_ready), 32'd0);
        check("midrst_we", 32'(rf_write_enabled), 32'd0);
        check("midrst_cnt", 32'(conflict_count), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_prio0", 32'(wr0_ready), 32'd1);
        check("post_rst_cnt", 32'(conflict_count), 32'd0);
        tick();
        idle();
        check("post_rst_cnt1", 32'(conflict_count), 32'd1);

        // File contents survive arbiter reset.
        rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd5;
        tick();
        idle();
        #1;
        check("persist_a", 32'(rd_data_a), 32'h1234);
        check("persist_b", 32'(rd_data_b), 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_regfile_arbiter
